// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake on both sides and a registered flag set.
// Define SEQ_ALU_MUL_EN to build the multi-cycle shift-add multiplier (op 111).
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q, state_d;
    logic             xfer, is_mul, mul_last;
    logic [WIDTH+2:0] ev;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
    logic             ovf_q, ovf_d, err_q, err_d;

    // Single-cycle evaluation; packed as {err, ovf, carry, result}.
    function automatic logic [WIDTH+2:0] alu_eval(
        input logic [2:0]       opc,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             ci
    );
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] res;
        logic             c, v, e;
        ext = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        e   = 1'b0;
        case (opc)
            OP_ADD: begin
                ext = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
                res = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (x[WIDTH-1] == y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the borrow.
                ext = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, ci};
                res = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (x[WIDTH-1] != y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND: res = x & y;
            OP_OR:  res = x | y;
            OP_XOR: res = x ^ y;
            OP_SHL: begin
                res = {x[WIDTH-2:0], 1'b0};
                c   = x[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, x[WIDTH-1:1]};
                c   = x[0];
            end
            default: e = 1'b1;
        endcase
        return {e, v, c, res};
    endfunction

`ifdef SEQ_ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b111;
    localparam int         CW     = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q, acc_hi_q, acc_lo_q, hi_n, lo_n;
    logic [WIDTH:0]   step_sum;

    assign is_mul   = (op == OP_MUL);
    assign mul_last = (state_q == EXEC) && (cnt_q == '0);

    // One shift-add step: {acc_hi, acc_lo} holds partial product and remaining multiplier bits.
    always_comb begin
        step_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        hi_n     = step_sum[WIDTH:1];
        lo_n     = {step_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (xfer && is_mul)
            cnt_q <= CW'(WIDTH - 1);
        else if (state_q == EXEC)
            cnt_q <= cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (xfer && is_mul) begin
            mcand_q  <= a;
            acc_hi_q <= '0;
            acc_lo_q <= b;
        end else if (state_q == EXEC) begin
            acc_hi_q <= hi_n;
            acc_lo_q <= lo_n;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_last = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (xfer) state_d = is_mul ? EXEC : DONE;
            EXEC: if (mul_last) state_d = DONE;
            DONE: begin
                if (xfer)
                    state_d = is_mul ? EXEC : DONE;
                else if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
    end

    assign xfer = in_valid && in_ready;

    always_comb begin
        ev          = alu_eval(op, a, b, cin);
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        if (xfer && !is_mul) begin
            result_d    = ev[WIDTH-1:0];
            result_hi_d = '0;
            carry_d     = ev[WIDTH];
            ovf_d       = ev[WIDTH+1];
            err_d       = ev[WIDTH+2];
            zero_d      = !ev[WIDTH+2] && (ev[WIDTH-1:0] == '0);
            neg_d       = ev[WIDTH-1];
        end
`ifdef SEQ_ALU_MUL_EN
        else if (mul_last) begin
            result_d    = lo_n;
            result_hi_d = hi_n;
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            err_d       = 1'b0;
            zero_d      = ({hi_n, lo_n} == '0);
            neg_d       = lo_n[WIDTH-1];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with a valid/ready handshake on both sides and a registered flag set. It is the next-generation arithmetic unit of the datapath: it accepts one operation per transfer and returns a registered result, carry/borrow and status flags. The width is configurable, undefined opcodes are reported explicitly, and an optional multi-cycle shift-add multiplier is included.

## Interface
- WIDTH, 4: operand and result width in bits; legal values are 2 or more.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand/opcode transfer request.
- in_ready  out  1  block can accept a transfer this cycle.
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- a, b  in  WIDTH  operands, unsigned, or two's complement for overflow purposes.
- cin  in  1  carry-in for ADD, borrow-in for SUB; ignored by all other ops.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  WIDTH  low result word.
- result_hi  out  WIDTH  high product word for MUL; 0 for all other ops.
- carry  out  1  carry-out (ADD), borrow (SUB), or the shifted-out bit (SHL/SHR).
- zero  out  1  result is all zero; for MUL this covers {result_hi, result}.
- neg  out  1  MSB of result.
- ovf  out  1  signed overflow for ADD/SUB; 0 otherwise.
- err  out  1  opcode not supported in this build.

## Operation
- States:
  - IDLE: in_ready=1.
  - EXEC: multiply in progress, in_ready=0.
  - DONE: out_valid=1.
- Transfer occurs when in_valid && in_ready. Operands and op are captured at the transfer edge; later input changes have no effect.
- Non-MUL transfer: the result and all flags are computed and registered at the same edge. The FSM goes to DONE.
- MUL transfer: the FSM goes to EXEC and loads a WIDTH-cycle counter. One shift-add step runs per cycle. On the last step it goes to DONE with the 2*WIDTH-bit unsigned product split into result_hi:result.
- DONE with out_ready=1: the result is consumed.
  - If in_valid=1 in the same cycle, the new op is accepted back-to-back: in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Otherwise the FSM returns to IDLE.
- DONE with out_ready=0: all outputs hold stable.
- Arithmetic:
  - ADD: {carry,result} = a+b+cin.
  - SUB: result = a-b-cin, and carry=1 iff a < b+cin.
  - ovf: set when the operand signs make a signed result impossible, per standard two's-complement rules.
  - SHL: result = a<<1, carry = a[WIDTH-1].
  - SHR: logical shift, result = a>>1, carry = a[0].
  - b is ignored for SHL and SHR.
- Flags for logic ops: carry=0 and ovf=0.
- Illegal opcode: completes in one cycle like a non-MUL op, with result=0, result_hi=0, all flags 0 and err=1. err=0 for every legal op.
- Reset: asserting rst_n low at any time, including mid-EXEC, immediately forces:
  - state IDLE, with the multiply abandoned;
  - out_valid=0, result=0, result_hi=0;
  - carry=0, zero=0, neg=0, ovf=0, err=0.
  - in_ready is 1 while in reset.

## Timing
- Non-MUL latency: transfer at edge N gives out_valid=1 after edge N. Sustained throughput is one op per cycle when out_ready is held high.
- MUL latency: transfer at edge N gives out_valid=1 after edge N+WIDTH. in_ready=0 during EXEC.
- out_valid deasserts at the edge after a cycle with out_valid && out_ready, unless a new non-MUL op was accepted in that same cycle.
- Outputs are driven only from registers; there is no combinational path from inputs to result or flags.
- in_ready depends combinationally on out_ready in DONE only.

## Configuration
- SEQ_ALU_MUL_EN:
  - Defined: the EXEC state, counter and shift-add datapath are built, and op 111 = MUL.
  - Undefined: no multiplier logic, op 111 is illegal (err=1, one-cycle latency), result_hi is constant 0 and the FSM never enters EXEC.

## Test plan
- WIDTH=8, ADD a=0xF0, b=0x20, cin=1, out_ready=1 → one cycle later result=0x11, carry=1, ovf=0, zero=0.
- SUB a=0x80, b=0x01, cin=0 → result=0x7F, carry=0, ovf=1, neg=0. Then SUB a=0x05, b=0x05, cin=0 → result=0x00, zero=1, carry=0.
- Back-to-back AND then OR with out_ready=1 and in_valid=1 on consecutive cycles → two results on consecutive cycles, in_ready never drops. With out_ready=0, result holds and in_ready=0 until released.
- With SEQ_ALU_MUL_EN defined, MUL a=0xFF, b=0xFF → out_valid exactly 8 cycles after transfer, result_hi=0xFE, result=0x01. Without the macro, op 111 gives err=1, result=0, after 1 cycle.
- MUL started, rst_n pulsed low at EXEC cycle 3 → all outputs 0 immediately and state IDLE. The next ADD a=1, b=1 returns result=0x02 normally.
- WIDTH=4, SHL a=0x9 → result=0x2, carry=1. SHR a=0x9 → result=0x4, carry=1.
